// File: rtl/pe_filter_unpacker_pkg.sv
// Shared NoC definitions for the SNN mesh: packet field layout, type codes,
// mesh addresses and the filter unpacker FSM state encoding.
package snn_noc_pkg;

  localparam int PKT_W      = 35;
  localparam int ADDR_W     = 4;
  localparam int TYPE_W     = 3;
  localparam int PAYLOAD_W  = 24;
  localparam int SRC_HI     = 34;
  localparam int SRC_LO     = 31;
  localparam int DST_HI     = 30;
  localparam int DST_LO     = 27;
  localparam int TYPE_HI    = 26;
  localparam int TYPE_LO    = 24;
  localparam int PAYLOAD_HI = 23;

  localparam logic [TYPE_W-1:0] PKT_FILTER = 3'b000;
  localparam logic [TYPE_W-1:0] PKT_ACK    = 3'b111;

  // Odd PEs carry 3-weight filter rows, even PEs 2-weight rows.
  localparam logic [ADDR_W-1:0] ADDR_FILTER_SRC = 4'b0100;
  localparam logic [ADDR_W-1:0] ADDR_PE1  = 4'b1000;
  localparam logic [ADDR_W-1:0] ADDR_PE2  = 4'b1100;
  localparam logic [ADDR_W-1:0] ADDR_PE3  = 4'b1001;
  localparam logic [ADDR_W-1:0] ADDR_PE4  = 4'b1101;
  localparam logic [ADDR_W-1:0] ADDR_PE5  = 4'b1010;
  localparam logic [ADDR_W-1:0] ADDR_PE6  = 4'b1110;
  localparam logic [ADDR_W-1:0] ADDR_PE7  = 4'b1011;
  localparam logic [ADDR_W-1:0] ADDR_PE8  = 4'b1111;
  localparam logic [ADDR_W-1:0] ADDR_PE9  = 4'b0001;
  localparam logic [ADDR_W-1:0] ADDR_PE10 = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UNPACK = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

endpackage

// File: rtl/pe_filter_unpacker_if.sv
// Local-port bundle between the mesh router and the PE filter unpacker:
// inbound filter packets and the outbound acknowledge packet.
interface pe_filter_unpacker_if #(
  parameter int WIDTH = 35
);
  // Both channels: a transfer happens on a rising clk edge where valid && ready;
  // the sender holds data stable while valid is high and unaccepted, and may
  // withdraw an unaccepted inbound packet without error.
  logic             pkt_in_valid;
  logic             pkt_in_ready;
  logic [WIDTH-1:0] pkt_in_data;
  logic             ack_valid;
  logic             ack_ready;
  logic [WIDTH-1:0] ack_data;

  modport master (
    output pkt_in_valid, pkt_in_data, ack_ready,
    input  pkt_in_ready, ack_valid, ack_data
  );

  modport slave (
    input  pkt_in_valid, pkt_in_data, ack_ready,
    output pkt_in_ready, ack_valid, ack_data
  );
endinterface

// File: rtl/pe_filter_unpacker_weight_byte_sel.sv
// Picks weight byte k out of a 3-byte filter payload, b0 (most significant) first.
module weight_byte_sel #(
  parameter int DATA_SIZE = 8
) (
  input  logic [3*DATA_SIZE-1:0] payload,
  input  logic [1:0]             idx,
  output logic [DATA_SIZE-1:0]   weight
);

  always_comb begin
    weight = '0;
    case (idx)
      2'd0:    weight = payload[3*DATA_SIZE-1 -: DATA_SIZE];
      2'd1:    weight = payload[2*DATA_SIZE-1 -: DATA_SIZE];
      2'd2:    weight = payload[DATA_SIZE-1:0];
      default: weight = '0;
    endcase
  end

endmodule

// File: rtl/pe_filter_unpacker.sv
// PE-side filter unpacker: filters NoC packets by address/type and serialises
// the weights into the local weight RF. Optional ack packet under `FILTER_ACK_EN.
module pe_filter_unpacker
  import snn_noc_pkg::*;
#(
  parameter int         WIDTH       = 35,
  parameter int         DATA_SIZE   = 8,
  parameter logic [3:0] PE_ADDR     = 4'b1000,
  parameter int         NUM_WEIGHTS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  pe_filter_unpacker_if.slave  noc,
  output logic                 w_wr_en,
  output logic [1:0]           w_wr_idx,
  output logic [DATA_SIZE-1:0] w_wr_data,
  output logic                 filter_loaded,
  input  logic                 filter_clear,
  output logic [7:0]           drop_cnt,
  output state_t               state
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_WEIGHTS - 1);

  logic [3*DATA_SIZE-1:0] payload_q;
  logic [3*DATA_SIZE-1:0] sel_payload;
  logic [1:0]             sel_idx;
  logic [DATA_SIZE-1:0]   sel_byte;
  logic                   accept;
  logic                   match;
  logic                   last;

  assign accept = (state == ST_IDLE) && noc.pkt_in_valid && noc.pkt_in_ready;
  assign match  = (noc.pkt_in_data[DST_HI:DST_LO] == PE_ADDR) &&
                  (noc.pkt_in_data[TYPE_HI:TYPE_LO] == PKT_FILTER);
  assign last   = (w_wr_idx == LAST_IDX);

  // Byte 0 is written straight from the incoming packet so the first RF write
  // lands the cycle after acceptance; later bytes come from the latched copy.
  always_comb begin
    sel_payload = payload_q;
    sel_idx     = w_wr_idx + 2'd1;
    if (state == ST_IDLE) begin
      sel_payload = noc.pkt_in_data[PAYLOAD_HI:0];
      sel_idx     = 2'd0;
    end
  end

  weight_byte_sel #(.DATA_SIZE(DATA_SIZE)) u_sel (
    .payload (sel_payload),
    .idx     (sel_idx),
    .weight  (sel_byte)
  );

`ifdef FILTER_ACK_EN
  logic [ADDR_W-1:0] src_q;
`else
  assign noc.ack_valid = 1'b0;
  assign noc.ack_data  = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      noc.pkt_in_ready <= 1'b0;
      w_wr_en          <= 1'b0;
      w_wr_idx         <= 2'd0;
      w_wr_data        <= '0;
      filter_loaded    <= 1'b0;
      drop_cnt         <= 8'd0;
      payload_q        <= '0;
`ifdef FILTER_ACK_EN
      src_q            <= '0;
      noc.ack_valid    <= 1'b0;
      noc.ack_data     <= '0;
`endif
    end else begin
      w_wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          noc.pkt_in_ready <= 1'b1;
          if (filter_clear) filter_loaded <= 1'b0;
          if (accept) begin
            if (match) begin
              payload_q        <= noc.pkt_in_data[PAYLOAD_HI:0];
`ifdef FILTER_ACK_EN
              src_q            <= noc.pkt_in_data[SRC_HI:SRC_LO];
`endif
              filter_loaded    <= 1'b0;
              w_wr_en          <= 1'b1;
              w_wr_idx         <= 2'd0;
              w_wr_data        <= sel_byte;
              noc.pkt_in_ready <= 1'b0;
              state            <= ST_UNPACK;
            end else if (drop_cnt != 8'hFF) begin
              drop_cnt <= drop_cnt + 8'd1;
            end
          end
        end

        ST_UNPACK: begin
          if (last) begin
            // Setting wins over a coincident filter_clear.
            filter_loaded <= 1'b1;
`ifdef FILTER_ACK_EN
            noc.ack_valid <= 1'b1;
            noc.ack_data  <= {PE_ADDR, src_q, PKT_ACK, 24'h0};
            state         <= ST_ACK;
`else
            noc.pkt_in_ready <= 1'b1;
            state            <= ST_IDLE;
`endif
          end else begin
            w_wr_en   <= 1'b1;
            w_wr_idx  <= w_wr_idx + 2'd1;
            w_wr_data <= sel_byte;
          end
        end

        ST_ACK: begin
`ifdef FILTER_ACK_EN
          if (filter_clear) filter_loaded <= 1'b0;
          if (noc.ack_valid && noc.ack_ready) begin
            noc.ack_valid    <= 1'b0;
            noc.ack_data     <= '0;
            noc.pkt_in_ready <= 1'b1;
            state            <= ST_IDLE;
          end
`else
          noc.pkt_in_ready <= 1'b1;
          state            <= ST_IDLE;
`endif
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_filter_unpacker.sv
// Directed bench for pe_filter_unpacker: an odd PE (3 weights) and an even PE
// (2 weights) side by side; ack checks follow `FILTER_ACK_EN.
module tb_pe_filter_unpacker;
  import snn_noc_pkg::*;

`ifdef FILTER_ACK_EN
  localparam bit ACK_ON = 1'b1;
`else
  localparam bit ACK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic filter_clear;
  int   checks   = 0;
  int   failures = 0;

  pe_filter_unpacker_if #(.WIDTH(35)) odd_if ();
  pe_filter_unpacker_if #(.WIDTH(35)) even_if ();

  logic       odd_wr_en,  even_wr_en;
  logic [1:0] odd_wr_idx, even_wr_idx;
  logic [7:0] odd_wr_data, even_wr_data;
  logic       odd_loaded, even_loaded;
  logic [7:0] odd_drop,   even_drop;
  state_t     odd_state,  even_state;

  pe_filter_unpacker #(.WIDTH(35), .DATA_SIZE(8), .PE_ADDR(4'b1000), .NUM_WEIGHTS(3)) u_odd (
    .clk(clk), .reset(reset), .noc(odd_if),
    .w_wr_en(odd_wr_en), .w_wr_idx(odd_wr_idx), .w_wr_data(odd_wr_data),
    .filter_loaded(odd_loaded), .filter_clear(filter_clear),
    .drop_cnt(odd_drop), .state(odd_state)
  );

  pe_filter_unpacker #(.WIDTH(35), .DATA_SIZE(8), .PE_ADDR(4'b1100), .NUM_WEIGHTS(2)) u_even (
    .clk(clk), .reset(reset), .noc(even_if),
    .w_wr_en(even_wr_en), .w_wr_idx(even_wr_idx), .w_wr_data(even_wr_data),
    .filter_loaded(even_loaded), .filter_clear(filter_clear),
    .drop_cnt(even_drop), .state(even_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog timeout");
  end

  // ---------------- driver tasks ----------------
  function automatic logic [34:0] mk(input logic [3:0] dst, input logic [2:0] typ,
                                     input logic [23:0] pay);
    return {4'b0100, dst, typ, pay};
  endfunction

  task automatic send(input bit to_even, input logic [34:0] d);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    if (to_even) begin even_if.pkt_in_valid = 1'b1; even_if.pkt_in_data = d; end
    else         begin odd_if.pkt_in_valid  = 1'b1; odd_if.pkt_in_data  = d; end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = to_even ? even_if.pkt_in_ready : odd_if.pkt_in_ready;
      @(posedge clk); #1;
    end
    odd_if.pkt_in_valid  = 1'b0;
    even_if.pkt_in_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_accept: pkt_in_ready got 0 within 20 cycles, expected 1");
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    filter_clear = 1'b0;
    odd_if.pkt_in_valid = 1'b0;  odd_if.pkt_in_data = '0;  odd_if.ack_ready = 1'b1;
    even_if.pkt_in_valid = 1'b0; even_if.pkt_in_data = '0; even_if.ack_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({odd_if.pkt_in_ready, odd_wr_en, odd_wr_idx, odd_wr_data, odd_loaded, odd_drop} !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b en=%b idx=%0d data=%h ld=%b drop=%0d, expected all 0",
               odd_if.pkt_in_ready, odd_wr_en, odd_wr_idx, odd_wr_data, odd_loaded, odd_drop);
    end
    checks++;
    if ({odd_if.ack_valid, odd_if.ack_data} !== 36'd0) begin
      failures++;
      $display("FAIL reset_ack: got valid=%b data=%h, expected 0", odd_if.ack_valid, odd_if.ack_data);
    end
    checks++;
    if (odd_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d expected %0d", odd_state, ST_IDLE);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (odd_if.pkt_in_ready !== 1'b1 || even_if.pkt_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: got odd=%b even=%b expected 1",
               odd_if.pkt_in_ready, even_if.pkt_in_ready);
    end
  endtask

  task automatic test_odd_unpack();
    logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
    send(1'b0, mk(4'b1000, 3'b000, 24'h112233));
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if ({odd_wr_en, odd_wr_idx, odd_wr_data, odd_loaded} !== {1'b1, 2'(j), exp[j], 1'b0}) begin
        failures++;
        $display("FAIL odd_write%0d: got en=%b idx=%0d data=%h ld=%b expected en=1 idx=%0d data=%h ld=0",
                 j, odd_wr_en, odd_wr_idx, odd_wr_data, odd_loaded, j, exp[j]);
      end
    end
    @(negedge clk);
    checks++;
    if ({odd_wr_en, odd_loaded, odd_if.pkt_in_ready} !== {1'b0, 1'b1, !ACK_ON}) begin
      failures++;
      $display("FAIL odd_loaded: got en=%b ld=%b rdy=%b expected en=0 ld=1 rdy=%b",
               odd_wr_en, odd_loaded, odd_if.pkt_in_ready, !ACK_ON);
    end
  endtask

  task automatic test_even_unpack();
    logic [7:0] exp [2] = '{8'hA5, 8'h5A};
    send(1'b1, mk(4'b1100, 3'b000, 24'hA55A00));
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      checks++;
      if ({even_wr_en, even_wr_idx, even_wr_data} !== {1'b1, 2'(j), exp[j]}) begin
        failures++;
        $display("FAIL even_write%0d: got en=%b idx=%0d data=%h expected en=1 idx=%0d data=%h",
                 j, even_wr_en, even_wr_idx, even_wr_data, j, exp[j]);
      end
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (even_wr_en !== 1'b0) begin
        failures++;
        $display("FAIL even_no_idx2: extra write idx=%0d data=%h, expected no write",
                 even_wr_idx, even_wr_data);
      end
    end
    checks++;
    if (even_loaded !== 1'b1) begin
      failures++;
      $display("FAIL even_loaded: got %b expected 1", even_loaded);
    end
  endtask

  task automatic test_drop();
    send(1'b0, mk(4'b0001, 3'b000, 24'h010203));
    send(1'b0, mk(4'b1000, 3'b010, 24'h040506));
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (odd_wr_en !== 1'b0) begin
        failures++;
        $display("FAIL drop_no_write: got en=1 idx=%0d expected en=0", odd_wr_idx);
      end
    end
    checks++;
    if ({odd_drop, odd_loaded} !== {8'd2, 1'b1}) begin
      failures++;
      $display("FAIL drop_count: got drop=%0d ld=%b expected drop=2 ld=1", odd_drop, odd_loaded);
    end
    checks++;
    if (even_drop !== 8'd0) begin
      failures++;
      $display("FAIL even_drop_untouched: got %0d expected 0", even_drop);
    end
    @(posedge clk); #1;
    odd_if.pkt_in_valid = 1'b1;
    odd_if.pkt_in_data  = mk(4'b0011, 3'b000, 24'hFFFFFF);
    repeat (300) @(posedge clk);
    #1 odd_if.pkt_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (odd_drop !== 8'd255) begin
      failures++;
      $display("FAIL drop_saturate: got %0d expected 255", odd_drop);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [3] = '{8'h44, 8'h55, 8'h66};
    send(1'b0, mk(4'b1000, 3'b000, 24'h445566));
    @(negedge clk);
    checks++;
    if ({odd_wr_en, odd_wr_idx, odd_wr_data, odd_loaded} !== {1'b1, 2'd0, 8'h44, 1'b0}) begin
      failures++;
      $display("FAIL reload_first: got en=%b idx=%0d data=%h ld=%b expected en=1 idx=0 data=44 ld=0",
               odd_wr_en, odd_wr_idx, odd_wr_data, odd_loaded);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({odd_if.pkt_in_ready, odd_wr_en, odd_wr_idx, odd_wr_data, odd_loaded, odd_drop} !== 21'd0
        || odd_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_mid: got rdy=%b en=%b idx=%0d data=%h ld=%b drop=%0d st=%0d expected all 0",
               odd_if.pkt_in_ready, odd_wr_en, odd_wr_idx, odd_wr_data, odd_loaded, odd_drop, odd_state);
    end
    @(posedge clk); #1 reset = 1'b0;
    send(1'b0, mk(4'b1000, 3'b000, 24'h445566));
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if ({odd_wr_en, odd_wr_idx, odd_wr_data} !== {1'b1, 2'(j), exp[j]}) begin
        failures++;
        $display("FAIL resend_write%0d: got en=%b idx=%0d data=%h expected en=1 idx=%0d data=%h",
                 j, odd_wr_en, odd_wr_idx, odd_wr_data, j, exp[j]);
      end
    end
    @(negedge clk);
    checks++;
    if (odd_loaded !== 1'b1) begin
      failures++;
      $display("FAIL resend_loaded: got %b expected 1", odd_loaded);
    end
  endtask

  task automatic test_clear();
    logic [7:0] exp [3] = '{8'h01, 8'h02, 8'h03};
    send(1'b0, mk(4'b1000, 3'b000, 24'hAABBCC));
    @(negedge clk);
    checks++;
    if (odd_loaded !== 1'b0) begin
      failures++;
      $display("FAIL reload_low: got ld=%b expected 0", odd_loaded);
    end
    @(negedge clk);
    @(posedge clk); #1 filter_clear = 1'b1;
    @(negedge clk);
    checks++;
    if ({odd_wr_en, odd_wr_idx, odd_wr_data} !== {1'b1, 2'd2, 8'hCC}) begin
      failures++;
      $display("FAIL clear_last_write: got en=%b idx=%0d data=%h expected en=1 idx=2 data=cc",
               odd_wr_en, odd_wr_idx, odd_wr_data);
    end
    @(posedge clk); #1 filter_clear = 1'b0;
    @(negedge clk);
    checks++;
    if (odd_loaded !== 1'b1) begin
      failures++;
      $display("FAIL set_wins: got ld=%b expected 1", odd_loaded);
    end
    @(posedge clk); #1 filter_clear = 1'b1;
    @(posedge clk); #1 filter_clear = 1'b0;
    @(negedge clk);
    checks++;
    if (odd_loaded !== 1'b0) begin
      failures++;
      $display("FAIL clear_idle: got ld=%b expected 0", odd_loaded);
    end
    send(1'b0, mk(4'b1000, 3'b000, 24'h010203));
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if ({odd_wr_en, odd_wr_idx, odd_wr_data} !== {1'b1, 2'(j), exp[j]}) begin
        failures++;
        $display("FAIL overwrite%0d: got en=%b idx=%0d data=%h expected en=1 idx=%0d data=%h",
                 j, odd_wr_en, odd_wr_idx, odd_wr_data, j, exp[j]);
      end
    end
    @(negedge clk);
    checks++;
    if (odd_loaded !== 1'b1) begin
      failures++;
      $display("FAIL overwrite_loaded: got %b expected 1", odd_loaded);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_a [3] = '{8'h77, 8'h88, 8'h99};
    logic [7:0] exp_b [3] = '{8'h0A, 8'h0B, 8'h0C};
    send(1'b0, mk(4'b1000, 3'b000, 24'h778899));
    odd_if.pkt_in_valid = 1'b1;
    odd_if.pkt_in_data  = mk(4'b1000, 3'b000, 24'h0A0B0C);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if ({odd_wr_en, odd_wr_idx, odd_wr_data, odd_if.pkt_in_ready} !== {1'b1, 2'(j), exp_a[j], 1'b0}) begin
        failures++;
        $display("FAIL b2b_a%0d: got en=%b idx=%0d data=%h rdy=%b expected en=1 idx=%0d data=%h rdy=0",
                 j, odd_wr_en, odd_wr_idx, odd_wr_data, odd_if.pkt_in_ready, j, exp_a[j]);
      end
    end
`ifdef FILTER_ACK_EN
    @(negedge clk);
    checks++;
    if (odd_if.pkt_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ack_gap: got rdy=%b expected 0", odd_if.pkt_in_ready);
    end
`endif
    @(negedge clk);
    checks++;
    if ({odd_if.pkt_in_ready, odd_loaded} !== 2'b11) begin
      failures++;
      $display("FAIL b2b_ready: got rdy=%b ld=%b expected rdy=1 ld=1", odd_if.pkt_in_ready, odd_loaded);
    end
    @(posedge clk); #1 odd_if.pkt_in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if ({odd_wr_en, odd_wr_idx, odd_wr_data, odd_loaded} !== {1'b1, 2'(j), exp_b[j], 1'b0}) begin
        failures++;
        $display("FAIL b2b_b%0d: got en=%b idx=%0d data=%h ld=%b expected en=1 idx=%0d data=%h ld=0",
                 j, odd_wr_en, odd_wr_idx, odd_wr_data, odd_loaded, j, exp_b[j]);
      end
    end
    @(negedge clk);
  endtask

`ifdef FILTER_ACK_EN
  task automatic test_ack();
    logic [34:0] exp_ack;
    exp_ack = {4'b1000, 4'b0100, 3'b111, 24'h0};
    odd_if.ack_ready = 1'b0;
    send(1'b0, mk(4'b1000, 3'b000, 24'h123456));
    repeat (3) @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checks++;
      if ({odd_if.ack_valid, odd_if.ack_data, odd_if.pkt_in_ready} !== {1'b1, exp_ack, 1'b0}) begin
        failures++;
        $display("FAIL ack_hold%0d: got v=%b data=%h rdy=%b expected v=1 data=%h rdy=0",
                 j, odd_if.ack_valid, odd_if.ack_data, odd_if.pkt_in_ready, exp_ack);
      end
    end
    @(posedge clk); #1 odd_if.ack_ready = 1'b1;
    @(posedge clk); #1 odd_if.ack_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({odd_if.ack_valid, odd_if.pkt_in_ready, odd_loaded} !== 3'b011 || odd_state !== ST_IDLE) begin
      failures++;
      $display("FAIL ack_done: got v=%b rdy=%b ld=%b st=%0d expected v=0 rdy=1 ld=1 st=0",
               odd_if.ack_valid, odd_if.pkt_in_ready, odd_loaded, odd_state);
    end
    odd_if.ack_ready = 1'b1;
  endtask
`else
  task automatic test_ack();
    odd_if.ack_ready = 1'b1;
    send(1'b0, mk(4'b1000, 3'b000, 24'h123456));
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checks++;
      if ({odd_if.ack_valid, odd_if.ack_data} !== 36'd0) begin
        failures++;
        $display("FAIL ack_disabled%0d: got v=%b data=%h expected v=0 data=0",
                 j, odd_if.ack_valid, odd_if.ack_data);
      end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_odd_unpack();
    test_even_unpack();
    test_drop();
    test_reset_mid();
    test_clear();
    test_back_to_back();
    test_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
